bcd_time_counter: RTL and testbench

Parametrised BCD time-of-day counter, the next generation of the alarm-clock minute counter. It keeps hours and minutes, plus optional seconds, in packed BCD, in 12-hour (with AM/PM) or 24-hour mode. It advances on a single-cycle tick from the frequency divider and accepts validated parallel loads. It sits between the clock divider and the display/alarm-compare logic, and flags midnight rollover and rejected loads.

---
 rtl/bcd_time_counter_if.sv | 33 +++
 rtl/bcd_time_counter.sv | 141 ++++++++++++++
 tb/tb_bcd_time_counter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/bcd_time_counter_if.sv
// bcd_time_counter_if -- connects the time-of-day counter to its driver
// (the clock divider and the time-set logic) and to its consumers (the
// display and the alarm compare).
//   tick              one-cycle advance strobe
//   time_in           packed BCD time to load ({HH,MM} or {HH,MM,SS})
//   pm_in             AM/PM of the loaded time (12-hour mode only)
//   load_new_time     load request
//   current_time_out  current packed BCD time
//   pm_out            PM indicator
//   day_rollover      one-cycle pulse on the midnight wrap
//   load_error        one-cycle pulse when a load is rejected
interface bcd_time_counter_if #(
  parameter int TW = 16
);
  logic          tick;
  logic [TW-1:0] time_in;
  logic          pm_in;
  logic          load_new_time;
  logic [TW-1:0] current_time_out;
  logic          pm_out;
  logic          day_rollover;
  logic          load_error;

  modport master (
    output tick, time_in, pm_in, load_new_time,
    input  current_time_out, pm_out, day_rollover, load_error
  );

  modport slave (
    input  tick, time_in, pm_in, load_new_time,
    output current_time_out, pm_out, day_rollover, load_error
  );
endinterface

// File: rtl/bcd_time_counter.sv
// bcd_time_counter -- packed BCD time-of-day counter (HH:MM or HH:MM:SS),
// 12-hour with AM/PM or 24-hour. Advances one unit per tick, accepts
// validated parallel loads, and flags the midnight wrap and rejected loads.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   bus    bcd_time_counter_if slave (tick/load in, time/pm/flags out)
module bcd_time_counter #(
  parameter bit HAS_SECONDS = 1'b0,
  parameter bit MODE_24H    = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  bcd_time_counter_if.slave  bus
);
  localparam int TW = HAS_SECONDS ? 24 : 16;

  logic [7:0] hh_q, mm_q, ss_q;
  logic [7:0] hh_n, mm_n, ss_n;
  logic       pm_q, pm_n;
  logic       roll_q, roll_n;
  logic       err_q, err_n;
  logic [7:0] ld_hh, ld_mm, ld_ss;
  logic       ld_ok;
  logic       c_s, c_m;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic hr_ge12(input logic [7:0] h);
    return (h[7:4] >= 4'd2) || ((h[7:4] == 4'd1) && (h[3:0] >= 4'd2));
  endfunction

  assign ld_hh = bus.time_in[TW-1 -: 8];
  assign ld_mm = bus.time_in[TW-9 -: 8];

  generate
    if (HAS_SECONDS) begin : g_sec
      assign ld_ss                = bus.time_in[7:0];
      assign bus.current_time_out = {hh_q, mm_q, ss_q};
    end else begin : g_nosec
      assign ld_ss                = 8'h00;
      assign bus.current_time_out = {hh_q, mm_q};
    end
  endgenerate

  assign bus.pm_out       = pm_q;
  assign bus.day_rollover = roll_q;
  assign bus.load_error   = err_q;

  always_comb begin
    ld_ok = (ld_hh[3:0] <= 4'd9) && (ld_mm[7:4] <= 4'd5) && (ld_mm[3:0] <= 4'd9) &&
            (ld_ss[7:4] <= 4'd5) && (ld_ss[3:0] <= 4'd9);
    if (MODE_24H)
      ld_ok = ld_ok && ((ld_hh[7:4] <= 4'd1) || ((ld_hh[7:4] == 4'd2) && (ld_hh[3:0] <= 4'd3)));
    else
      ld_ok = ld_ok && (((ld_hh[7:4] == 4'd0) && (ld_hh[3:0] != 4'd0)) ||
                        ((ld_hh[7:4] == 4'd1) && (ld_hh[3:0] <= 4'd2)));
  end

  always_comb begin
    hh_n   = hh_q;
    mm_n   = mm_q;
    ss_n   = ss_q;
    pm_n   = pm_q;
    roll_n = 1'b0;
    err_n  = 1'b0;
    c_s    = 1'b0;
    c_m    = 1'b0;
    if (bus.load_new_time) begin
      // A load wins over a coincident tick; the tick is simply dropped.
      if (ld_ok) begin
        hh_n = ld_hh;
        mm_n = ld_mm;
        ss_n = ld_ss;
        pm_n = MODE_24H ? hr_ge12(ld_hh) : bus.pm_in;
      end else begin
        err_n = 1'b1;
      end
    end else if (bus.tick) begin
      if (HAS_SECONDS) begin
        if (ss_q == 8'h59) begin
          ss_n = 8'h00;
          c_s  = 1'b1;
        end else begin
          ss_n = bcd_inc(ss_q);
        end
      end else begin
        c_s = 1'b1;
      end
      if (c_s) begin
        if (mm_q == 8'h59) begin
          mm_n = 8'h00;
          c_m  = 1'b1;
        end else begin
          mm_n = bcd_inc(mm_q);
        end
      end
      if (c_m) begin
        if (MODE_24H) begin
          if (hh_q == 8'h23) begin
            hh_n   = 8'h00;
            roll_n = 1'b1;
          end else begin
            hh_n = bcd_inc(hh_q);
          end
          pm_n = hr_ge12(hh_n);
        end else if (hh_q == 8'h12) begin
          hh_n = 8'h01;
        end else if (hh_q == 8'h11) begin
          // 11 -> 12 flips AM/PM; coming out of PM this is midnight.
          hh_n   = 8'h12;
          pm_n   = ~pm_q;
          roll_n = pm_q;
        end else begin
          hh_n = bcd_inc(hh_q);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hh_q   <= MODE_24H ? 8'h00 : 8'h12;
      mm_q   <= 8'h00;
      ss_q   <= 8'h00;
      pm_q   <= 1'b0;
      roll_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      hh_q   <= hh_n;
      mm_q   <= mm_n;
      ss_q   <= ss_n;
      pm_q   <= pm_n;
      roll_q <= roll_n;
      err_q  <= err_n;
    end
  end
endmodule

// File: tb/tb_bcd_time_counter.sv
// tb_bcd_time_counter -- directed bench for bcd_time_counter.
// Two instances: u12 (12-hour, HH:MM) and u24 (24-hour, HH:MM:SS).
// Each step drives one cycle of stimulus, queues the expected outputs,
// and compares them against the DUT one cycle later.
module tb_bcd_time_counter;
  logic clk = 1'b0;
  logic rst12 = 1'b1;
  logic rst24 = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   roll_cnt = 0;
  logic bad_digit = 1'b0;

  always #5 clk = ~clk;

  bcd_time_counter_if #(.TW(16)) b12 ();
  bcd_time_counter_if #(.TW(24)) b24 ();

  bcd_time_counter #(.HAS_SECONDS(1'b0), .MODE_24H(1'b0)) u12 (
    .clk(clk), .reset(rst12), .bus(b12)
  );
  bcd_time_counter #(.HAS_SECONDS(1'b1), .MODE_24H(1'b1)) u24 (
    .clk(clk), .reset(rst24), .bus(b24)
  );

  typedef struct {
    string       tag;
    bit          sel;
    logic [23:0] t;
    logic        pm;
    logic        roll;
    logic        err;
  } exp_t;

  exp_t sb[$];

  // Independent reference for the 12-hour long run: minutes since midnight.
  function automatic logic [16:0] model12(input int m);
    int h24 = m / 60;
    int mi  = m % 60;
    int h12 = (h24 % 12 == 0) ? 12 : h24 % 12;
    return {(h24 >= 12), 4'(h12 / 10), 4'(h12 % 10), 4'(mi / 10), 4'(mi % 10)};
  endfunction

  task automatic check(input exp_t e);
    logic [23:0] ot;
    logic        op, orl, oe;
    ot  = e.sel ? b24.current_time_out : {8'h00, b12.current_time_out};
    op  = e.sel ? b24.pm_out       : b12.pm_out;
    orl = e.sel ? b24.day_rollover : b12.day_rollover;
    oe  = e.sel ? b24.load_error   : b12.load_error;
    n_assert++;
    assert (ot === e.t) else begin
      n_fail++;
      $error("FAIL %s time: observed %h expected %h", e.tag, ot, e.t);
    end
    n_assert++;
    assert (op === e.pm) else begin
      n_fail++;
      $error("FAIL %s pm_out: observed %b expected %b", e.tag, op, e.pm);
    end
    n_assert++;
    assert (orl === e.roll) else begin
      n_fail++;
      $error("FAIL %s day_rollover: observed %b expected %b", e.tag, orl, e.roll);
    end
    n_assert++;
    assert (oe === e.err) else begin
      n_fail++;
      $error("FAIL %s load_error: observed %b expected %b", e.tag, oe, e.err);
    end
  endtask

  task automatic step(input bit sel, input logic rst_v, input logic ld, input logic tk,
                      input logic [23:0] tin, input logic pin, input string tag,
                      input logic [23:0] et, input logic ep, input logic er, input logic ee);
    exp_t e;
    if (!sel) begin
      rst12 = rst_v; b12.load_new_time = ld; b12.tick = tk;
      b12.time_in = tin[15:0]; b12.pm_in = pin;
    end else begin
      rst24 = rst_v; b24.load_new_time = ld; b24.tick = tk;
      b24.time_in = tin; b24.pm_in = pin;
    end
    e.tag = tag; e.sel = sel; e.t = et; e.pm = ep; e.roll = er; e.err = ee;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(e);
    if (!sel) begin
      rst12 = 1'b1; b12.load_new_time = 1'b0; b12.tick = 1'b0;
    end else begin
      rst24 = 1'b1; b24.load_new_time = 1'b0; b24.tick = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [16:0] m;
    logic [15:0] tv;
    b12.tick = 1'b0; b12.load_new_time = 1'b0; b12.time_in = '0; b12.pm_in = 1'b0;
    b24.tick = 1'b0; b24.load_new_time = 1'b0; b24.time_in = '0; b24.pm_in = 1'b0;

    // ---------------- 12-hour, HH:MM ----------------
    step(0, 0, 0, 0, 24'h0,    0, "rst12_a",     24'h1200, 0, 0, 0);
    step(0, 0, 0, 0, 24'h0,    0, "rst12_b",     24'h1200, 0, 0, 0);
    step(0, 1, 0, 0, 24'h0,    0, "hold12",      24'h1200, 0, 0, 0);
    step(0, 1, 1, 0, 24'h1236, 1, "load1236",    24'h1236, 1, 0, 0);
    step(0, 1, 0, 1, 24'h0,    0, "tick1237",    24'h1237, 1, 0, 0);
    step(0, 1, 0, 1, 24'h0,    0, "tick1238",    24'h1238, 1, 0, 0);
    step(0, 1, 1, 0, 24'h0959, 0, "load0959",    24'h0959, 0, 0, 0);
    step(0, 1, 0, 1, 24'h0,    0, "tick1000",    24'h1000, 0, 0, 0);
    step(0, 1, 1, 0, 24'h1159, 0, "load1159am",  24'h1159, 0, 0, 0);
    step(0, 1, 0, 1, 24'h0,    0, "noon",        24'h1200, 1, 0, 0);
    step(0, 1, 1, 0, 24'h1259, 1, "load1259pm",  24'h1259, 1, 0, 0);
    step(0, 1, 0, 1, 24'h0,    0, "tick0100",    24'h0100, 1, 0, 0);
    step(0, 1, 1, 0, 24'h1159, 1, "load1159pm",  24'h1159, 1, 0, 0);
    step(0, 1, 0, 1, 24'h0,    0, "midnight",    24'h1200, 0, 1, 0);
    step(0, 1, 0, 0, 24'h0,    0, "roll_end",    24'h1200, 0, 0, 0);
    step(0, 1, 1, 0, 24'h1360, 1, "bad1360",     24'h1200, 0, 0, 1);
    step(0, 1, 0, 0, 24'h0,    0, "err_end",     24'h1200, 0, 0, 0);
    step(0, 1, 1, 0, 24'h0000, 1, "bad0000",     24'h1200, 0, 0, 1);
    step(0, 1, 1, 1, 24'h0815, 0, "ld_tick",     24'h0815, 0, 0, 0);
    step(0, 1, 0, 0, 24'h0,    0, "hold0815",    24'h0815, 0, 0, 0);
    step(0, 0, 1, 1, 24'h0930, 1, "rst_ld_tick", 24'h1200, 0, 0, 0);

    // Long run: 1440 ticks from 12:00 AM back to 12:00 AM.
    for (int k = 1; k <= 1440; k++) begin
      m = model12(k % 1440);
      step(0, 1, 0, 1, {8'h00, m[15:0]}, 0, "long", {8'h00, m[15:0]}, m[16], (k == 1440), 0);
      tv = b12.current_time_out;
      for (int j = 0; j < 4; j++)
        if (tv[j*4 +: 4] > 4'd9) bad_digit = 1'b1;
      if (b12.day_rollover === 1'b1) roll_cnt++;
    end
    n_assert++;
    assert (roll_cnt === 1) else begin
      n_fail++;
      $error("FAIL long_rollovers: observed %0d expected 1", roll_cnt);
    end
    n_assert++;
    assert (bad_digit === 1'b0) else begin
      n_fail++;
      $error("FAIL long_digits: observed %b expected 0", bad_digit);
    end

    // ---------------- 24-hour, HH:MM:SS ----------------
    step(1, 0, 0, 0, 24'h0,      0, "rst24_a",   24'h000000, 0, 0, 0);
    step(1, 0, 0, 0, 24'h0,      0, "rst24_b",   24'h000000, 0, 0, 0);
    step(1, 1, 1, 0, 24'h235959, 0, "ld235959",  24'h235959, 1, 0, 0);
    step(1, 1, 0, 1, 24'h0,      0, "wrap24",    24'h000000, 0, 1, 0);
    step(1, 1, 0, 0, 24'h0,      0, "wrap24end", 24'h000000, 0, 0, 0);
    step(1, 1, 1, 0, 24'h095959, 0, "ld095959",  24'h095959, 0, 0, 0);
    step(1, 1, 0, 1, 24'h0,      0, "tick10",    24'h100000, 0, 0, 0);
    step(1, 1, 1, 0, 24'h115959, 0, "ld115959",  24'h115959, 0, 0, 0);
    step(1, 1, 0, 1, 24'h0,      0, "tick12",    24'h120000, 1, 0, 0);
    step(1, 1, 1, 0, 24'h195959, 0, "ld195959",  24'h195959, 1, 0, 0);
    step(1, 1, 0, 1, 24'h0,      0, "tick20",    24'h200000, 1, 0, 0);
    step(1, 1, 1, 0, 24'h1A0000, 0, "bad1A",     24'h200000, 1, 0, 1);
    step(1, 1, 1, 0, 24'h240000, 0, "bad24",     24'h200000, 1, 0, 1);
    step(1, 1, 1, 0, 24'h006000, 0, "bad60",     24'h200000, 1, 0, 1);
    step(1, 1, 0, 0, 24'h0,      0, "err24end",  24'h200000, 1, 0, 0);
    step(1, 1, 1, 0, 24'h083000, 1, "pm_ignore", 24'h083000, 0, 0, 0);
    step(1, 1, 1, 1, 24'h123456, 0, "ld_tick24", 24'h123456, 1, 0, 0);
    step(1, 1, 1, 0, 24'h000058, 0, "ld000058",  24'h000058, 0, 0, 0);
    step(1, 1, 0, 1, 24'h0,      0, "b2b_1",     24'h000059, 0, 0, 0);
    step(1, 1, 0, 1, 24'h0,      0, "b2b_2",     24'h000100, 0, 0, 0);
    step(1, 0, 1, 1, 24'h101010, 0, "rst24_mid", 24'h000000, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
